axis_ramp_pkt_checker: RTL

//  Synthesizable AXI-Stream sink that consumes ramp packets and checks them: beat i of every packet must equal
//  cfg_ramp_start + i*cfg_ramp_inc (mod 2^DWIDTH), and packet length must equal cfg_pkt_len.

---
 rtl/axis_ramp_pkt_checker.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_ramp_pkt_checker.sv
// AXI-Stream sink that checks incoming packets against a programmable ramp and an expected length.
// Drives tready with a selectable backpressure pattern and keeps saturating statistics counters.
module axis_ramp_pkt_checker #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned LEN_W  = 16,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic [DWIDTH-1:0] cfg_ramp_start,
   input  logic [DWIDTH-1:0] cfg_ramp_inc,
   input  logic [LEN_W-1:0]  cfg_pkt_len,
   input  logic [1:0]        cfg_ready_mode,
   input  logic [DWIDTH-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [CNT_W-1:0]  data_err_cnt,
   output logic [CNT_W-1:0]  len_err_cnt,
   output logic              err_sticky,
   output logic [DWIDTH-1:0] err_data,
   output logic [DWIDTH-1:0] err_expected
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PKT  = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [15:0]      LFSR_SEED = 16'hACE1;

   state_t            state;
   state_t            state_nxt;

   logic [15:0]       lfsr;
   logic              lfsr_fb;
   logic              toggle;
   logic              tready_r;

   logic [DWIDTH-1:0] acc;
   logic [DWIDTH-1:0] inc_sh;
   logic [LEN_W-1:0]  len_sh;
   logic [LEN_W-1:0]  idx;

   logic              beat;
   logic [DWIDTH-1:0] exp_cur;
   logic [DWIDTH-1:0] inc_cur;
   logic [LEN_W-1:0]  len_cur;
   logic [LEN_W-1:0]  idx_cur;
   logic              len_on;
   logic              at_last_idx;
   logic              data_bad;
   logic              short_err;
   logic              over_err;
   logic              len_bad;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   assign beat          = s_axis_tvalid & tready_r;
   assign s_axis_tready = tready_r;

   // ---------------------------------------------------------------- ready generation
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr     <= LFSR_SEED;
         toggle   <= 1'b1;
         tready_r <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
         if (clear) begin
            toggle   <= 1'b1;
            tready_r <= 1'b0;
         end else begin
            toggle <= ~toggle;
            case (cfg_ready_mode)
               2'd0:    tready_r <= 1'b1;
               2'd1:    tready_r <= 1'b0;
               2'd2:    tready_r <= lfsr[0];
               default: tready_r <= toggle;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else if (clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      state_nxt = state;
      if (beat) begin
         case (state)
            S_IDLE, S_PKT: begin
               if (s_axis_tlast) begin
                  state_nxt = S_IDLE;
               end else if (over_err) begin
                  state_nxt = S_OVER;
               end else begin
                  state_nxt = S_PKT;
               end
            end
            S_OVER: begin
               if (s_axis_tlast) begin
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM: beat evaluation
   // Beat 0 is checked straight against the live config; later beats use the shadows
   // latched on beat 0, so config edits mid-packet have no effect.
   always_comb begin
      exp_cur = acc;
      inc_cur = inc_sh;
      len_cur = len_sh;
      idx_cur = idx;
      if (state == S_IDLE) begin
         exp_cur = cfg_ramp_start;
         inc_cur = cfg_ramp_inc;
         len_cur = cfg_pkt_len;
         idx_cur = '0;
      end
      len_on      = (len_cur != '0) && (state != S_OVER);
      at_last_idx = (idx_cur == (len_cur - LEN_ONE));
      data_bad    = beat && (s_axis_tdata != exp_cur);
      short_err   = beat && len_on && s_axis_tlast && !at_last_idx;
      over_err    = beat && len_on && !s_axis_tlast && at_last_idx;
      len_bad     = short_err || over_err;
   end

   // ---------------------------------------------------------------- ramp tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         inc_sh <= '0;
         len_sh <= '0;
         idx    <= '0;
      end else if (clear) begin
         acc    <= '0;
         inc_sh <= '0;
         len_sh <= '0;
         idx    <= '0;
      end else if (beat) begin
         acc <= exp_cur + inc_cur;
         idx <= idx_cur + LEN_ONE;
         if (state == S_IDLE) begin
            inc_sh <= cfg_ramp_inc;
            len_sh <= cfg_pkt_len;
         end
      end
   end

   // ---------------------------------------------------------------- statistics
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_cnt      <= '0;
         word_cnt     <= '0;
         data_err_cnt <= '0;
         len_err_cnt  <= '0;
         err_sticky   <= 1'b0;
         err_data     <= '0;
         err_expected <= '0;
      end else if (clear) begin
         pkt_cnt      <= '0;
         word_cnt     <= '0;
         data_err_cnt <= '0;
         len_err_cnt  <= '0;
         err_sticky   <= 1'b0;
         err_data     <= '0;
         err_expected <= '0;
      end else if (beat) begin
         word_cnt <= sat_inc(word_cnt);
         if (s_axis_tlast) begin
            pkt_cnt <= sat_inc(pkt_cnt);
         end
         if (data_bad) begin
            data_err_cnt <= sat_inc(data_err_cnt);
            err_data     <= s_axis_tdata;
            err_expected <= exp_cur;
         end
         if (len_bad) begin
            len_err_cnt <= sat_inc(len_err_cnt);
         end
         if (data_bad || len_bad) begin
            err_sticky <= 1'b1;
         end
      end
   end

endmodule
